// File: rtl/fetch_pkg.sv
// Shared encodings and state type for the instruction fetch stage.
package fetch_pkg;

   localparam logic [1:0] PCTYPE_BRANCH = 2'b00;
   localparam logic [1:0] PCTYPE_JREG   = 2'b01;
   localparam logic [1:0] PCTYPE_JABS   = 2'b10;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Redirect target mux: selects the decode-supplied target and word-aligns it.
module fetch_next_pc
   import fetch_pkg::*;
(
   input  logic [1:0]  selpctype,
   input  logic [31:0] pcimd2ext,
   input  logic [31:0] rega,
   input  logic [31:0] pcindex,
   output logic [31:0] target
);

   logic [31:0] raw_target;

   always_comb begin
      raw_target = pcimd2ext;
      case (selpctype)
         PCTYPE_BRANCH: raw_target = pcimd2ext;
         PCTYPE_JREG:   raw_target = rega;
         PCTYPE_JABS:   raw_target = pcindex;
         default:       raw_target = pcimd2ext;
      endcase
   end

   assign target = {raw_target[31:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request handshake, skid buffer and IF/ID register.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] if_id_instruc,
   output logic [31:0] if_id_nextpc,
   input  logic        id_if_selpcsource,
   input  logic [1:0]  id_if_selpctype,
   input  logic [31:0] id_if_pcimd2ext,
   input  logic [31:0] id_if_rega,
   input  logic [31:0] id_if_pcindex,
   input  logic        id_stall,
   output logic        if_mem_req,
   output logic [31:0] if_mem_addr,
   input  logic        mem_if_ack,
   input  logic [31:0] mem_if_data
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  skid_instr_reg, skid_instr_next;
   logic [31:0]  skid_nextpc_reg, skid_nextpc_next;
   logic [31:0]  redir_pc_reg, redir_pc_next;
   logic [31:0]  if_id_instr_reg, if_id_instr_next;
   logic [31:0]  if_id_nextpc_reg, if_id_nextpc_next;

   logic [31:0]  target;
   logic [31:0]  pc_plus4;
   logic         redir;

   fetch_next_pc u_next_pc (
      .selpctype (id_if_selpctype),
      .pcimd2ext (id_if_pcimd2ext),
      .rega      (id_if_rega),
      .pcindex   (id_if_pcindex),
      .target    (target)
   );

   // A stalled decode cannot act on its own redirect request.
   assign redir    = id_if_selpcsource & ~id_stall;
   assign pc_plus4 = pc_reg + 32'd4;

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      skid_instr_next   = skid_instr_reg;
      skid_nextpc_next  = skid_nextpc_reg;
      redir_pc_next     = redir_pc_reg;
      if_id_instr_next  = if_id_instr_reg;
      if_id_nextpc_next = if_id_nextpc_reg;

      case (state_reg)
         FETCH: begin
            if (mem_if_ack) begin
               if (!id_stall) begin
                  if_id_instr_next  = mem_if_data;
                  if_id_nextpc_next = pc_plus4;
                  pc_next           = redir ? target : pc_plus4;
               end else begin
                  skid_instr_next  = mem_if_data;
                  skid_nextpc_next = pc_plus4;
                  pc_next          = pc_plus4;
                  state_next       = HOLD;
               end
            end else begin
               if (redir) begin
                  redir_pc_next = target;
                  state_next    = DROP;
               end
               if (!id_stall) begin
                  if_id_instr_next  = NOP_INSTR;
                  if_id_nextpc_next = pc_reg;
               end
            end
         end
         HOLD: begin
            if (!id_stall) begin
               if_id_instr_next  = skid_instr_reg;
               if_id_nextpc_next = skid_nextpc_reg;
               state_next        = FETCH;
            end
         end
         DROP: begin
            // The stale response is swallowed; the latest redirect target wins.
            if (redir) begin
               redir_pc_next = target;
            end
            if (mem_if_ack) begin
               pc_next    = redir ? target : redir_pc_reg;
               state_next = FETCH;
            end
            if (!id_stall) begin
               if_id_instr_next  = NOP_INSTR;
               if_id_nextpc_next = pc_reg;
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= FETCH;
         pc_reg           <= RESET_PC;
         skid_instr_reg   <= 32'd0;
         skid_nextpc_reg  <= 32'd0;
         redir_pc_reg     <= 32'd0;
         if_id_instr_reg  <= NOP_INSTR;
         if_id_nextpc_reg <= RESET_PC;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         skid_instr_reg   <= skid_instr_next;
         skid_nextpc_reg  <= skid_nextpc_next;
         redir_pc_reg     <= redir_pc_next;
         if_id_instr_reg  <= if_id_instr_next;
         if_id_nextpc_reg <= if_id_nextpc_next;
      end
   end

   assign if_mem_req    = (state_reg != HOLD) & ~reset;
   assign if_mem_addr   = pc_reg;
   assign if_id_instruc = if_id_instr_reg;
   assign if_id_nextpc  = if_id_nextpc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table plus multi-cycle corner sequences.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic [31:0] if_id_instruc;
   logic [31:0] if_id_nextpc;
   logic        id_if_selpcsource;
   logic [1:0]  id_if_selpctype;
   logic [31:0] id_if_pcimd2ext;
   logic [31:0] id_if_rega;
   logic [31:0] id_if_pcindex;
   logic        id_stall;
   logic        if_mem_req;
   logic [31:0] if_mem_addr;
   logic        mem_if_ack;
   logic [31:0] mem_if_data;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_unit dut (
      .clock             (clock),
      .reset             (reset),
      .if_id_instruc     (if_id_instruc),
      .if_id_nextpc      (if_id_nextpc),
      .id_if_selpcsource (id_if_selpcsource),
      .id_if_selpctype   (id_if_selpctype),
      .id_if_pcimd2ext   (id_if_pcimd2ext),
      .id_if_rega        (id_if_rega),
      .id_if_pcindex     (id_if_pcindex),
      .id_stall          (id_stall),
      .if_mem_req        (if_mem_req),
      .if_mem_addr       (if_mem_addr),
      .mem_if_ack        (mem_if_ack),
      .mem_if_data       (mem_if_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        ack;
      logic [31:0] data;
      logic        sel;
      logic [1:0]  typ;
      logic [31:0] imd;
      logic [31:0] rega;
      logic [31:0] idx;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_instr;
      logic [31:0] exp_np;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic r, input logic st, input logic a, input logic [31:0] d,
                        input logic s, input logic [1:0] t, input logic [31:0] imd,
                        input logic [31:0] rg, input logic [31:0] ix);
      @(negedge clock);
      reset             = r;
      id_stall          = st;
      mem_if_ack        = a;
      mem_if_data       = d;
      id_if_selpcsource = s;
      id_if_selpctype   = t;
      id_if_pcimd2ext   = imd;
      id_if_rega        = rg;
      id_if_pcindex     = ix;
      #1;
   endtask

   task automatic cyc(input logic r, input logic st, input logic a, input logic [31:0] d,
                      input logic s, input logic [31:0] tgt);
      drive(r, st, a, d, s, 2'b00, tgt, tgt, tgt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; id_stall = 1'b0; mem_if_ack = 1'b0; mem_if_data = 32'd0;
      id_if_selpcsource = 1'b0; id_if_selpctype = 2'b00;
      id_if_pcimd2ext = 32'd0; id_if_rega = 32'd0; id_if_pcindex = 32'd0;

      // rst stall ack data sel typ imd rega idx | req addr instr nextpc
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b0, 32'h0, NOP, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h0, NOP, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h1,  1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h4, 32'h0, 32'h4};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h2,  1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h8, 32'h1, 32'h8};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h3,  1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'hC, 32'h2, 32'hC};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 2'b01, 32'h500, 32'h103, 32'h600,
                   1'b1, 32'h10, 32'h3, 32'h10};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h100, 32'h4, 32'h14};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h104, 32'h40, 32'h104};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h41, 1'b1, 2'b10, 32'h700, 32'h800, 32'h203,
                   1'b1, 32'h104, NOP, 32'h104};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 2'b11, 32'h30A, 32'h900, 32'hA00,
                   1'b1, 32'h200, 32'h41, 32'h108};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 32'hC2, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h4, 32'h8,
                   1'b1, 32'h308, 32'h80, 32'h204};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'hFFFF_FFFC, 32'hC2, 32'h30C};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h0, 32'h55, 32'h0};

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].ack, vecs[i].data, vecs[i].sel,
               vecs[i].typ, vecs[i].imd, vecs[i].rega, vecs[i].idx);
         chk($sformatf("vec%0d_req", i),   {31'd0, if_mem_req}, {31'd0, vecs[i].exp_req});
         chk($sformatf("vec%0d_addr", i),  if_mem_addr,   vecs[i].exp_addr);
         chk($sformatf("vec%0d_instr", i), if_id_instruc, vecs[i].exp_instr);
         chk($sformatf("vec%0d_nextpc", i), if_id_nextpc, vecs[i].exp_np);
         $display("vec %0d: req=%0b addr=%h instr=%h nextpc=%h",
                  i, if_mem_req, if_mem_addr, if_id_instruc, if_id_nextpc);
      end

      // Three-cycle ack latency: two bubbles per instruction, address held.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("lat_req0", {31'd0, if_mem_req}, 32'd1);
      chk("lat_addr0a", if_mem_addr, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("lat_addr0b", if_mem_addr, 32'h0);
      chk("lat_bubble0", if_id_instruc, NOP);
      cyc(0, 0, 1, 32'hAA, 0, 0);
      chk("lat_addr0c", if_mem_addr, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("lat_instr_aa", if_id_instruc, 32'hAA);
      chk("lat_np_aa", if_id_nextpc, 32'h4);
      chk("lat_addr4a", if_mem_addr, 32'h4);
      cyc(0, 0, 0, 0, 0, 0);
      chk("lat_bubble1", if_id_instruc, NOP);
      chk("lat_addr4b", if_mem_addr, 32'h4);
      cyc(0, 0, 1, 32'hBB, 0, 0);
      chk("lat_bubble2", if_id_instruc, NOP);
      cyc(0, 0, 0, 0, 0, 0);
      chk("lat_instr_bb", if_id_instruc, 32'hBB);
      chk("lat_addr8", if_mem_addr, 32'h8);
      $display("seq latency: instr=%h addr=%h", if_id_instruc, if_mem_addr);

      // Redirect while the request at 0x20 is unacked; stale word must be dropped.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h0, 1, 32'h20);
      cyc(0, 0, 0, 0, 1, 32'h40);
      chk("drop_addr20a", if_mem_addr, 32'h20);
      cyc(0, 0, 0, 0, 0, 0);
      chk("drop_req", {31'd0, if_mem_req}, 32'd1);
      chk("drop_addr20b", if_mem_addr, 32'h20);
      chk("drop_bubble0", if_id_instruc, NOP);
      cyc(0, 0, 1, 32'hDEAD, 0, 0);
      chk("drop_addr20c", if_mem_addr, 32'h20);
      cyc(0, 0, 0, 0, 0, 0);
      chk("drop_target_addr", if_mem_addr, 32'h40);
      chk("drop_no_stale", if_id_instruc, NOP);
      cyc(0, 0, 1, 32'h10, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("drop_instr", if_id_instruc, 32'h10);
      chk("drop_np", if_id_nextpc, 32'h44);
      $display("seq drop: instr=%h nextpc=%h", if_id_instruc, if_id_nextpc);

      // Ack during a 3-cycle stall lands in the skid buffer.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h11, 0, 0);
      cyc(0, 1, 1, 32'h22, 0, 0);
      chk("stall_addr4", if_mem_addr, 32'h4);
      chk("stall_instr0", if_id_instruc, 32'h11);
      cyc(0, 1, 0, 0, 0, 0);
      chk("stall_hold_req1", {31'd0, if_mem_req}, 32'd0);
      chk("stall_instr1", if_id_instruc, 32'h11);
      cyc(0, 1, 0, 0, 1, 32'h300);
      chk("stall_hold_req2", {31'd0, if_mem_req}, 32'd0);
      chk("stall_instr2", if_id_instruc, 32'h11);
      cyc(0, 0, 0, 0, 0, 0);
      chk("stall_hold_req3", {31'd0, if_mem_req}, 32'd0);
      chk("stall_instr3", if_id_instruc, 32'h11);
      cyc(0, 0, 0, 0, 0, 0);
      chk("stall_skid_instr", if_id_instruc, 32'h22);
      chk("stall_skid_np", if_id_nextpc, 32'h8);
      chk("stall_resume_req", {31'd0, if_mem_req}, 32'd1);
      chk("stall_resume_addr", if_mem_addr, 32'h8);
      $display("seq stall: instr=%h nextpc=%h addr=%h", if_id_instruc, if_id_nextpc, if_mem_addr);

      // Reset in the middle of DROP discards the pending redirect target.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h0, 1, 32'h60);
      cyc(0, 0, 0, 0, 1, 32'h80);
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_drop_addr", if_mem_addr, 32'h60);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_req_gated", {31'd0, if_mem_req}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_pc", if_mem_addr, 32'h0);
      chk("rst_instr", if_id_instruc, NOP);
      chk("rst_np", if_id_nextpc, 32'h0);
      chk("rst_req", {31'd0, if_mem_req}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_first_req", {31'd0, if_mem_req}, 32'd1);
      chk("rst_first_addr", if_mem_addr, 32'h0);
      cyc(0, 0, 1, 32'h77, 0, 0);
      chk("rst_no_redir_addr", if_mem_addr, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_after_addr", if_mem_addr, 32'h4);
      chk("rst_after_instr", if_id_instruc, 32'h77);
      $display("seq reset: instr=%h addr=%h", if_id_instruc, if_mem_addr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
